// File: rtl/cordic_sincos_postprocess.sv
// rtl/cordic_sincos_postprocess.sv - CORDIC sin/cos sign correction, FWFT output FIFO and pipeline enable
// Optional saturating negation of the most negative value: define CORDIC_POST_SAT_EN.
module cordic_sincos_postprocess #(
    parameter int BITS       = 16,
    parameter int STAGES     = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_valid,
    input  logic                          i_sign,
    input  logic [BITS-1:0]               i_cos,
    input  logic [BITS-1:0]               i_sin,
    output logic                          o_pipeline_en,
    output logic                          o_valid,
    input  logic                          i_ready,
    output logic [BITS-1:0]               o_cos,
    output logic [BITS-1:0]               o_sin,
    output logic [$clog2(FIFO_DEPTH):0]   o_level
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || STAGES < 1) begin : g_bad_cfg
        $error("cordic_sincos_postprocess: FIFO_DEPTH must be a power of two >= 2");
    end

    function automatic logic [BITS-1:0] negate(input logic [BITS-1:0] v);
`ifdef CORDIC_POST_SAT_EN
        if (v == {1'b1, {(BITS-1){1'b0}}}) begin
            return {1'b0, {(BITS-1){1'b1}}};
        end
`endif
        return ~v + 1'b1;
    endfunction

    logic            p1_valid_q, p1_valid_d;
    logic            p1_sign_q, p1_sign_d;
    logic [BITS-1:0] p1_cos_q, p1_cos_d;
    logic [BITS-1:0] p1_sin_q, p1_sin_d;
    logic            p2_valid_q, p2_valid_d;
    logic [BITS-1:0] p2_cos_q, p2_cos_d;
    logic [BITS-1:0] p2_sin_q, p2_sin_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]   level_q, level_d;
    logic [BITS-1:0] mem_cos_q [FIFO_DEPTH];
    logic [BITS-1:0] mem_sin_q [FIFO_DEPTH];

    logic fifo_full;
    logic pipeline_en;
    logic fifo_wr;
    logic fifo_rd;

    // Stall depends only on registered state, never on i_ready.
    assign fifo_full   = (level_q == LW'(FIFO_DEPTH));
    assign pipeline_en = !(p2_valid_q && fifo_full);
    assign fifo_wr     = p2_valid_q && pipeline_en;
    assign fifo_rd     = (level_q != '0) && i_ready;

    always_comb begin
        p1_valid_d = p1_valid_q;
        p1_sign_d  = p1_sign_q;
        p1_cos_d   = p1_cos_q;
        p1_sin_d   = p1_sin_q;
        p2_valid_d = p2_valid_q;
        p2_cos_d   = p2_cos_q;
        p2_sin_d   = p2_sin_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        if (pipeline_en) begin
            p1_valid_d = i_valid;
            p1_sign_d  = i_sign;
            p1_cos_d   = i_cos;
            p1_sin_d   = i_sin;
            p2_valid_d = p1_valid_q;
            p2_cos_d   = p1_sign_q ? negate(p1_cos_q) : p1_cos_q;
            p2_sin_d   = p1_sign_q ? negate(p1_sin_q) : p1_sin_q;
        end
        if (fifo_wr) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (fifo_rd) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({fifo_wr, fifo_rd})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            p1_valid_q <= 1'b0;
            p1_sign_q  <= 1'b0;
            p1_cos_q   <= '0;
            p1_sin_q   <= '0;
            p2_valid_q <= 1'b0;
            p2_cos_q   <= '0;
            p2_sin_q   <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
        end else begin
            p1_valid_q <= p1_valid_d;
            p1_sign_q  <= p1_sign_d;
            p1_cos_q   <= p1_cos_d;
            p1_sin_q   <= p1_sin_d;
            p2_valid_q <= p2_valid_d;
            p2_cos_q   <= p2_cos_d;
            p2_sin_q   <= p2_sin_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
        end
    end

    // Storage needs no reset; pointers and occupancy decide what is visible.
    always_ff @(posedge i_clk) begin
        if (fifo_wr) begin
            mem_cos_q[wr_ptr_q] <= p2_cos_q;
            mem_sin_q[wr_ptr_q] <= p2_sin_q;
        end
    end

    assign o_pipeline_en = pipeline_en;
    assign o_valid       = (level_q != '0);
    assign o_level       = level_q;
    assign o_cos         = o_valid ? mem_cos_q[rd_ptr_q] : '0;
    assign o_sin         = o_valid ? mem_sin_q[rd_ptr_q] : '0;

endmodule

// File: tb/tb_cordic_sincos_postprocess.sv
// tb/tb_cordic_sincos_postprocess.sv - self-checking bench for cordic_sincos_postprocess
module tb_cordic_sincos_postprocess;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_sign;
    logic [15:0] in_cos;
    logic [15:0] in_sin;
    logic        pipe_en;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_cos;
    logic [15:0] out_sin;
    logic [2:0]  out_level;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    cordic_sincos_postprocess #(.BITS(16), .STAGES(16), .FIFO_DEPTH(4)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_valid       (in_valid),
        .i_sign        (in_sign),
        .i_cos         (in_cos),
        .i_sin         (in_sin),
        .o_pipeline_en (pipe_en),
        .o_valid       (out_valid),
        .i_ready       (out_ready),
        .o_cos         (out_cos),
        .o_sin         (out_sin),
        .o_level       (out_level)
    );

    typedef struct {
        logic        sign;
        logic [15:0] cos_in;
        logic [15:0] sin_in;
        logic [15:0] cos_exp;
        logic [15:0] sin_exp;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] ref_neg(input logic [15:0] v);
        int n;
        n = -int'($signed(v));
`ifdef CORDIC_POST_SAT_EN
        if (n > 32767) n = 32767;
`endif
        return n[15:0];
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    vec_t vecs[8];
    logic [15:0] exp_cos_q[$];
    logic [15:0] exp_sin_q[$];

    initial begin
        rst = 1'b1; in_valid = 1'b1; in_sign = 1'b0; in_cos = 16'h1234; in_sin = 16'h4321; out_ready = 1'b1;

        vecs[0] = '{1'b0, 16'h2000, 16'h1000, 16'h2000, 16'h1000};
        vecs[1] = '{1'b1, 16'h2000, 16'hF000, 16'hE000, 16'h1000};
`ifdef CORDIC_POST_SAT_EN
        vecs[2] = '{1'b1, 16'h8000, 16'h0000, 16'h7FFF, 16'h0000};
`else
        vecs[2] = '{1'b1, 16'h8000, 16'h0000, 16'h8000, 16'h0000};
`endif
        vecs[3] = '{1'b1, 16'h7FFF, 16'h0001, 16'h8001, 16'hFFFF};
        vecs[4] = '{1'b1, 16'hFFFF, 16'h0000, 16'h0001, 16'h0000};
        vecs[5] = '{1'b0, 16'h8000, 16'h7FFF, 16'h8000, 16'h7FFF};
        vecs[6] = '{1'b1, 16'h0000, 16'h4000, 16'h0000, 16'hC000};
        vecs[7] = '{1'b0, 16'hFFFF, 16'hABCD, 16'hFFFF, 16'hABCD};

        // Reset held two cycles with valid input present.
        step();
        step();
        chk("rst_valid", out_valid, 0);
        chk("rst_level", out_level, 0);
        chk("rst_en", pipe_en, 1);
        chk("rst_cos", out_cos, 0);
        chk("rst_sin", out_sin, 0);
        rst = 1'b0; in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("rst_quiet", out_valid, 0);
        end

        // Single-sample vectors: latency, value, one-cycle output pulse.
        for (int v = 0; v < 8; v++) begin
            int lat;
            out_ready = 1'b1;
            in_valid = 1'b1; in_sign = vecs[v].sign; in_cos = vecs[v].cos_in; in_sin = vecs[v].sin_in;
            step();
            in_valid = 1'b0; in_cos = 16'h5A5A; in_sin = 16'hA5A5; in_sign = 1'b0;
            lat = 1;
            while (!out_valid && lat < 10) begin
                step();
                lat++;
            end
            chk($sformatf("vec%0d_latency", v), lat, 3);
            chk($sformatf("vec%0d_cos", v), out_cos, vecs[v].cos_exp);
            chk($sformatf("vec%0d_sin", v), out_sin, vecs[v].sin_exp);
            step();
            chk($sformatf("vec%0d_pulse", v), out_valid, 0);
        end

        // Backpressure: six samples into a four-deep FIFO with the sink stalled.
        do_reset();
        begin
            int idx;
            int guard;
            idx = 1; guard = 0;
            out_ready = 1'b0; in_sign = 1'b0;
            while (idx <= 6 && guard < 30) begin
                logic en_b;
                in_valid = 1'b1; in_cos = 16'(idx); in_sin = 16'(idx + 16'h0100);
                en_b = pipe_en;
                step();
                if (en_b) idx++;
                guard++;
            end
            chk("bp_all_fed", idx, 7);
            in_valid = 1'b0;
            chk("bp_level_full", out_level, 4);
            chk("bp_stalled", pipe_en, 0);
            step(); step();
            chk("bp_still_full", out_level, 4);
            chk("bp_still_stalled", pipe_en, 0);
            out_ready = 1'b1;
            for (int k = 1; k <= 6; k++) begin
                chk($sformatf("bp_valid%0d", k), out_valid, 1);
                chk($sformatf("bp_cos%0d", k), out_cos, k);
                chk($sformatf("bp_sin%0d", k), out_sin, k + 16'h0100);
                step();
            end
            chk("bp_drained", out_valid, 0);
            step();
            chk("bp_no_dup", out_valid, 0);
        end

        // Reset mid-stream: three entries queued, P1/P2 occupied.
        do_reset();
        out_ready = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            in_valid = 1'b1; in_cos = 16'(k); in_sin = 16'(k);
            step();
        end
        chk("mr_level_pre", out_level, 3);
        in_valid = 1'b0;
        rst = 1'b1;
        step();
        chk("mr_valid", out_valid, 0);
        chk("mr_level", out_level, 0);
        chk("mr_en", pipe_en, 1);
        rst = 1'b0;
        out_ready = 1'b1;
        begin
            int seen;
            seen = 0;
            for (int i = 0; i < 10; i++) begin
                step();
                if (out_valid) seen++;
            end
            chk("mr_no_stale", seen, 0);
        end

        // Randomized traffic against a queue-based reference.
        do_reset();
        begin
            logic        have_pend;
            logic        p_sign;
            logic [15:0] p_cos, p_sin;
            int          rdy_pct;
            int          guard;
            have_pend = 1'b0; p_sign = 1'b0; p_cos = '0; p_sin = '0;
            for (int cyc = 0; cyc < 1200; cyc++) begin
                logic en_b, ov_b;
                logic [15:0] oc_b, os_b;
                case ((cyc / 150) % 4)
                    0: rdy_pct = 90;
                    1: rdy_pct = 15;
                    2: rdy_pct = 50;
                    default: rdy_pct = 0;
                endcase
                if (!have_pend && $urandom_range(0, 3) != 0) begin
                    have_pend = 1'b1;
                    p_sign = 1'($urandom_range(0, 1));
                    p_cos = ($urandom_range(0, 7) == 0) ? 16'h8000 : 16'($urandom);
                    p_sin = ($urandom_range(0, 7) == 0) ? 16'h8000 : 16'($urandom);
                end
                in_valid = have_pend;
                in_sign  = have_pend ? p_sign : 1'($urandom_range(0, 1));
                in_cos   = have_pend ? p_cos : 16'($urandom);
                in_sin   = have_pend ? p_sin : 16'($urandom);
                out_ready = ($urandom_range(0, 99) < rdy_pct);
                en_b = pipe_en; ov_b = out_valid; oc_b = out_cos; os_b = out_sin;
                if (out_level > 4) chk("rnd_level_range", out_level, 4);
                if (out_level < 4 && !en_b) chk("rnd_no_false_stall", en_b, 1);
                if (!ov_b && (oc_b != 0 || os_b != 0)) chk("rnd_idle_zero", {oc_b, os_b}, 0);
                if (ov_b && out_ready) begin
                    if (exp_cos_q.size() == 0) begin
                        chk("rnd_extra_output", 1, 0);
                    end else begin
                        chk("rnd_cos", oc_b, exp_cos_q.pop_front());
                        chk("rnd_sin", os_b, exp_sin_q.pop_front());
                    end
                end
                if (en_b && in_valid) begin
                    exp_cos_q.push_back(p_sign ? ref_neg(p_cos) : p_cos);
                    exp_sin_q.push_back(p_sign ? ref_neg(p_sin) : p_sin);
                    have_pend = 1'b0;
                end
                step();
            end
            in_valid = 1'b0; out_ready = 1'b1;
            guard = 0;
            while (guard < 100 && (exp_cos_q.size() != 0 || out_valid)) begin
                if (out_valid) begin
                    if (exp_cos_q.size() == 0) begin
                        chk("drain_extra_output", 1, 0);
                    end else begin
                        chk("drain_cos", out_cos, exp_cos_q.pop_front());
                        chk("drain_sin", out_sin, exp_sin_q.pop_front());
                    end
                end
                step();
                guard++;
            end
            chk("drain_left", exp_cos_q.size(), 0);
            chk("drain_final_valid", out_valid, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/cordic_sincos_postprocess.md
Name: cordic_sincos_postprocess

Overview:
Output end of the CORDIC sin/cos pipeline, after the last CORDIC rotation stage. Reapplies the quadrant sign flag carried through the pipeline from angle correction, so results cover the full input range. Buffers results in a small first-word-fall-through (FWFT) FIFO with a valid/ready handshake toward the UART TX path. Generates the global pipeline enable that stalls the whole CORDIC pipeline under backpressure.

Parameters:
BITS, 16, width of the sin/cos datapath (signed two's complement, same fixed-point format as the CORDIC stages)
STAGES, 16, number of CORDIC rotation stages upstream; informational only, does not affect logic
FIFO_DEPTH, 4, output FIFO entries; power of two, >= 2

Ports:
i_clk  input  1  system clock
i_rst  input  1  synchronous reset, active-high
i_valid  input  1  result valid from the last CORDIC stage
i_sign  input  1  1 = negate both results (quadrant correction)
i_cos  input  BITS  signed cosine from the last CORDIC stage
i_sin  input  BITS  signed sine from the last CORDIC stage
o_pipeline_en  output  1  global pipeline advance enable; drives all CORDIC stages and this block's P1/P2
o_valid  output  1  FIFO head holds a result
i_ready  input  1  downstream accepts the head when o_valid is high
o_cos  output  BITS  corrected cosine at the FIFO head
o_sin  output  BITS  corrected sine at the FIFO head
o_level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset: one cycle of i_rst clears P1/P2 valids, FIFO pointers and occupancy. Afterwards o_valid=0, o_level=0, o_cos=o_sin=0, o_pipeline_en=1.
- Reset mid-operation discards in-flight P1/P2 data and all FIFO contents. No stale result appears after deassertion.
- P1 (register): when o_pipeline_en=1, capture i_valid, i_sign, i_cos, i_sin. When o_pipeline_en=0, hold all P1 values; upstream is frozen by the same enable and holds its outputs.
- P2 (register): when o_pipeline_en=1, capture p1_valid. If p1_sign=1, capture cos=-p1_cos and sin=-p1_sin; otherwise capture unchanged. Negation is BITS-wide two's complement.
- FIFO write: p2_valid && o_pipeline_en.
- FIFO read: o_valid && i_ready.
- o_pipeline_en = !(p2_valid && fifo_full), where fifo_full is (o_level==FIFO_DEPTH) and is register-derived. There is no combinational path from i_ready to o_pipeline_en.
- A bubble (p2_valid=0) never stalls the pipeline.
- Simultaneous read and write while not full: occupancy unchanged, both succeed. Write while full cannot occur.
- Read when empty is ignored. o_valid = (o_level != 0).
- o_cos/o_sin show the head entry when o_valid=1 and are forced to 0 when o_valid=0.
- Head updates the cycle after a read.
- Latency with no stall and empty FIFO: input sampled at edge E0 -> o_valid high after edge E2, i.e. 3 cycles from i_valid to o_valid. Each stalled cycle adds one.
- Order is strictly preserved. No loss or duplication under any i_ready pattern.
- Pointers wrap modulo FIFO_DEPTH.
- Negating the most negative value (-2^(BITS-1)) is governed by the optional feature.

Optional Feature:
Macro CORDIC_POST_SAT_EN.
- Defined: P2 negation saturates; -(-2^(BITS-1)) yields 2^(BITS-1)-1.
- Undefined: plain two's-complement negation; the most negative value stays unchanged (wraps).
- All other values are identical in both builds.

Test Plan:
1. Reset: hold i_rst 2 cycles, i_valid=1 throughout -> o_valid=0, o_level=0, o_pipeline_en=1, o_cos=o_sin=0x0000; no output appears until a valid is sampled after deassertion.
2. Pass-through, BITS=16: i_valid=1 for 1 cycle, i_sign=0, i_cos=0x2000, i_sin=0x1000, i_ready=1 -> o_valid high exactly 1 cycle, 3 cycles later, with o_cos=0x2000, o_sin=0x1000.
3. Sign correction: i_sign=1, i_cos=0x2000, i_sin=0xF000 -> o_cos=0xE000, o_sin=0x1000.
4. Backpressure, FIFO_DEPTH=4: i_ready=0, feed 6 consecutive samples 0x0001..0x0006 ->
   - o_level reaches 4.
   - o_pipeline_en=0 while sample 5 sits in P2, with sample 6 held in P1.
   - Raise i_ready -> 6 results emerge in order, one per cycle, none lost or duplicated.
5. Most-negative input: i_sign=1, i_cos=0x8000, i_sin=0x0000 -> o_cos=0x7FFF with CORDIC_POST_SAT_EN; o_cos=0x8000 without it. o_sin=0x0000 in both builds.
6. Reset mid-stream: 3 entries in FIFO, P1/P2 valid, i_ready=0; assert i_rst 1 cycle -> next cycle o_valid=0, o_level=0, o_pipeline_en=1. After deassertion with no new input, o_valid stays 0 for 10 cycles.
